rr_mux_arbiter: RTL
===================

# rr_mux_arbiter

Four-requester round-robin arbiter that owns the select of a 4:1 single-bit multiplexer. Each requester drives one mux input bit plus a request line; the arbiter grants one requester at a time, holds the grant until release, drives the mux select from the grant, and rotates priority fairly. It sits between independent single-bit sources and a shared downstream consumer of `f`.

## Interface
- `MAX_HOLD`, default 8: cycles an owner may hold the grant while others wait (used only with `RR_TIMEOUT_EN`); legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: request per requester; level-sensitive; held high for the whole transfer.
- `i` in 4: data bit per requester.
- `gnt` out 4: one-hot grant, registered; all-zero when idle.
- `sel` out 2: registered encoded owner index; drives the internal mux.
- `valid` out 1: registered; high when a grant is active (`gnt != 0`).
- `f` out 1: `i[sel]` when `valid`, else 0; combinational from `i`.

## Operation
- States: IDLE (no owner) and BUSY (owner = `sel`).
- Rotating pointer `ptr[1:0]` marks the highest-priority index; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4, wrap 3→0).
- IDLE: if `req != 0`, grant the first requester in search order and go to BUSY; else stay IDLE.
- BUSY, release (`req[sel]==0`), no other requests: go to IDLE, outputs cleared; `ptr = sel+1`.
- BUSY, release, others pending: hand over directly to the first pending requester in search order from `sel+1`; no idle bubble; `ptr = sel+1`.
- BUSY, `req[sel]` high: keep the owner (subject to timeout, see Configuration).
- Simultaneous requests resolve purely by the pointer; a requester asserting in the same cycle as a release competes normally.
- Grant is never given to an index whose `req` is low in the evaluating cycle.
- `gnt`, `sel` and `valid` are always mutually consistent: `gnt == 1<<sel` iff `valid`.
- Reset (any time, including mid-grant): `gnt=0`, `sel=0`, `valid=0`, `f=0`, `ptr=0`, state IDLE, hold counter 0. After reset, requester 0 has top priority.

## Timing
- Request-to-grant latency: 1 cycle (`req` sampled at edge N, `gnt`/`sel`/`valid` valid after edge N).
- Release-to-regrant: 1 cycle (`req[sel]` low at edge N → new `gnt` after edge N).
- `f` follows `i` combinationally within the same cycle; no registered data path.
- Requesters must not sample `f` before seeing their own `gnt` bit high.

## Configuration
- `RR_TIMEOUT_EN` defined: hold counter increments each BUSY cycle while the owner holds its grant and another requester is pending. When the counter reaches `MAX_HOLD`, the next edge forces a handover to the next pending requester in search order, with `ptr = sel+1`. The counter clears on any grant change. If no other request is pending, the counter does not advance and the owner keeps the grant indefinitely.
- Undefined: no counter is instantiated; the owner holds the grant until it drops `req`. `MAX_HOLD` is ignored.

## Structure
- Shared package `rr_arb_pkg`: state enum (IDLE, BUSY), `NUM_REQ=4`, `IDX_W=2`.
- One sub-module, `rr_pick4`: combinational rotating-priority picker. Inputs are `req` (masked) and a start index; outputs are found flag and index. It is used for both IDLE grant and handover.
- The mux itself is inline in the top: `f = valid & i[sel]`.

## Test plan
- Reset mid-grant: owner 2 active, pulse `rst_n` low → `gnt=0000`, `sel=0`, `valid=0`, `f=0` immediately; next `req=1111` → `gnt=0001`.
- Single request: `req=0100`, `i=1010` → after 1 edge `gnt=0100`, `sel=2`, `f=0`; drop `req` → next edge `gnt=0000`.
- Round-robin fairness: `req=1111` constant, each owner drops `req` for 1 cycle after 2 cycles of ownership → grant order 0,1,2,3,0 with no idle cycle between owners.
- Wrap-around: owner 3 releases with `req=0011` → next `gnt=0001`, then after that release `gnt=0010`.
- Mux data: `i=1100`, grant sequence 0,2,3,1 → `f` = 0,1,1,0 respectively.
- Timeout (`RR_TIMEOUT_EN`, `MAX_HOLD=4`): owner 0 holds `req`, `req[1]` high → `gnt` moves to `0010` exactly 5 edges after `req[1]` rises. With `req[1]` low, owner 0 keeps the grant indefinitely.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin mux arbiter.
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One-hot encode an owner index into a grant vector.
  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side bundle of the round-robin mux arbiter: request/data in,
// grant/select/valid and muxed data out.
interface rr_mux_arbiter_if;
  import rr_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] i;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   sel;
  logic               valid;
  logic               f;

  // Arbiter side.
  modport slave (
    input  req,
    input  i,
    output gnt,
    output sel,
    output valid,
    output f
  );

  // Requester / consumer side.
  modport master (
    output req,
    output i,
    input  gnt,
    input  sel,
    input  valid,
    input  f
  );

endinterface

// File: rtl/rr_mux_arbiter_pick4.sv
// Combinational rotating-priority picker: returns the first set bit of req
// scanning start, start+1, start+2, start+3 (mod 4).
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = start + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter driving the select of a 4:1 single-bit
// mux. Optional hold timeout is built when RR_TIMEOUT_EN is defined; without
// it the owner keeps the grant until it drops its request.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux_arbiter_if.slave   bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_mux_arbiter: MAX_HOLD must be within 1..255");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] pick_req;
  logic [IDX_W-1:0]   pick_start;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               hold_expired;

`ifdef RR_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign hold_expired = (cnt_q >= 8'(MAX_HOLD));
`else
  assign hold_expired = 1'b0;
`endif

  // Picker input: idle searches all requests from ptr; busy searches the
  // other requesters starting just after the current owner.
  always_comb begin
    if (state_q == BUSY) begin
      pick_req   = bus.req & ~gnt_q;
      pick_start = sel_q + IDX_W'(1);
    end else begin
      pick_req   = bus.req;
      pick_start = ptr_q;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state / next-output computation for the grant FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef RR_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          gnt_d   = idx2onehot(pick_idx);
          sel_d   = pick_idx;
          valid_d = 1'b1;
`ifdef RR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (!bus.req[sel_q] || (hold_expired && pick_found)) begin
          // Release or forced handover: the old owner moves to the back.
          ptr_d = sel_q + IDX_W'(1);
`ifdef RR_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (pick_found) begin
            gnt_d = idx2onehot(pick_idx);
            sel_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            valid_d = 1'b0;
          end
        end else begin
`ifdef RR_TIMEOUT_EN
          // Only time the owner while someone else is waiting.
          if (pick_found) begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Grant FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef RR_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef RR_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  // Inline 4:1 mux, gated so f is 0 with no owner.
  assign bus.f     = valid_q & bus.i[sel_q];

endmodule
